// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: controller states and
// the bundle of per-stage write-enable / flush controls.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    DWAIT  = 2'd2,
    HALT   = 2'd3
  } pipe_state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN = '{
    pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_write: 1'b1,
    id_ex_flush: 1'b0, ex_mem_write: 1'b1, mem_wb_flush: 1'b0};

  // Used both during reset and after a dmem timeout: nothing moves, everything drains to NOPs.
  localparam stage_ctrl_t CTRL_KILL = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1, id_ex_write: 1'b0,
    id_ex_flush: 1'b1, ex_mem_write: 1'b0, mem_wb_flush: 1'b1};

  localparam stage_ctrl_t CTRL_FREEZE = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_write: 1'b0,
    id_ex_flush: 1'b0, ex_mem_write: 1'b0, mem_wb_flush: 1'b1};

  localparam stage_ctrl_t CTRL_BRANCH = '{
    pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_write: 1'b1,
    id_ex_flush: 1'b1, ex_mem_write: 1'b1, mem_wb_flush: 1'b0};

  localparam stage_ctrl_t CTRL_LOAD_USE = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_write: 1'b1,
    id_ex_flush: 1'b1, ex_mem_write: 1'b1, mem_wb_flush: 1'b0};

  localparam stage_ctrl_t CTRL_IMEM_WAIT = '{
    pc_write: 1'b0, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_write: 1'b1,
    id_ex_flush: 1'b0, ex_mem_write: 1'b1, mem_wb_flush: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: prioritises dmem waits, branch
// redirects, load-use bubbles and fetch waits into per-stage enables and flushes.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             imem_valid,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_flush,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

  pipe_state_t state, next_state;
  logic [7:0]  wait_cnt, next_wait;
  stage_ctrl_t ctrl;
  logic        set_berr;
  logic        flush_inc;
  logic        stall_inc;
  logic        eval_run;
  logic        dmem_stall;
  logic        ack_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_wait;
      if (set_berr) begin
        bus_err <= 1'b1;
      end
    end
  end

  // An ack only counts while a request is actually outstanding.
  always_comb begin
    ctrl       = CTRL_RUN;
    next_state = state;
    next_wait  = '0;
    set_berr   = 1'b0;
    flush_inc  = 1'b0;
    eval_run   = 1'b0;
    dmem_stall = dmem_req && !dmem_ack;
    ack_valid  = dmem_req && dmem_ack;

    if (rst) begin
      ctrl = CTRL_KILL;
    end else begin
      case (state)
        HALT: begin
          ctrl = CTRL_KILL;
        end
        DWAIT: begin
          if (ack_valid) begin
            eval_run = 1'b1;
          end else begin
            ctrl      = CTRL_FREEZE;
            next_wait = wait_cnt + 8'd1;
            if (next_wait == TIMEOUT_W) begin
              next_state = HALT;
              set_berr   = 1'b1;
            end
          end
        end
        default: begin
          eval_run = 1'b1;
        end
      endcase
    end

    // Shared priority chain for RUN, BUBBLE and the DWAIT release cycle.
    if (eval_run) begin
      next_state = RUN;
      if (dmem_stall) begin
        ctrl       = CTRL_FREEZE;
        next_state = DWAIT;
        next_wait  = 8'd1;
      end else if (branch_taken) begin
        ctrl      = CTRL_BRANCH;
        flush_inc = 1'b1;
      end else if (load_use && (state != BUBBLE)) begin
        ctrl       = CTRL_LOAD_USE;
        next_state = BUBBLE;
      end else if (!imem_valid) begin
        ctrl = CTRL_IMEM_WAIT;
      end
    end
  end

  assign stall_inc = !ctrl.pc_write && !rst;

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_write  = ctrl.id_ex_write;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_write = ctrl.ex_mem_write;
  assign mem_wb_flush = ctrl.mem_wb_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_inc),
    .count(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (flush_inc),
    .count(flush_cnt)
  );

endmodule
